lu_arbiter: RTL

LU_ARBITER -- requirements
Module: lu_arbiter

---
 rtl/lu_arbiter_pkg.sv | 12 +
 rtl/lu_arbiter_logical_unit.sv | 16 +
 rtl/lu_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/lu_arbiter_pkg.sv
// lu_arbiter_pkg: shared width constants and logical-unit opcodes
package lu_arbiter_pkg;
  localparam int OPCODE_SIZE = 3;
  localparam int WORD_SIZE   = 19;
  localparam int LU_NUM_REQ  = 2;
  typedef enum logic [OPCODE_SIZE-1:0] {
    AND = 3'd0,
    OR  = 3'd1,
    XOR = 3'd2,
    NOT = 3'd3
  } opcode_e;
endpackage

// File: rtl/lu_arbiter_logical_unit.sv
// logical_unit: combinational AND/OR/XOR/NOT, zero for anything else
module logical_unit
  import lu_arbiter_pkg::*;
(
  input  logic [OPCODE_SIZE-1:0] opcode_i,
  input  logic [WORD_SIZE-1:0]   op1_i,
  input  logic [WORD_SIZE-1:0]   op2_i,
  output logic [WORD_SIZE-1:0]   result_o
);
  // NOT looks at op1 only
  always_comb
    result_o = (opcode_i == AND) ? op1_i & op2_i :
               (opcode_i == OR)  ? op1_i | op2_i :
               (opcode_i == XOR) ? op1_i ^ op2_i :
               (opcode_i == NOT) ? ~op1_i : '0;
endmodule

// File: rtl/lu_arbiter.sv
// lu_arbiter: round-robin share of one logical unit between two requesters
module lu_arbiter
  import lu_arbiter_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [LU_NUM_REQ-1:0]                   req_valid,
  output logic [LU_NUM_REQ-1:0]                   req_ready,
  input  logic [LU_NUM_REQ-1:0][OPCODE_SIZE-1:0]  req_opcode,
  input  logic [LU_NUM_REQ-1:0][WORD_SIZE-1:0]    req_op1,
  input  logic [LU_NUM_REQ-1:0][WORD_SIZE-1:0]    req_op2,
  output logic                                    resp_valid,
  input  logic                                    resp_ready,
  output logic [WORD_SIZE-1:0]                    resp_data,
  output logic                                    resp_id,
  output logic                                    resp_err
);
  typedef enum logic {IDLE, HOLD} state_e;

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 id_q, id_d;
  logic                 err_q, err_d;
  logic                 can_accept, gnt, gnt_id, legal;
  logic [WORD_SIZE-1:0] lu_res;

  function automatic logic is_legal(input logic [OPCODE_SIZE-1:0] op);
    return op == AND || op == OR || op == XOR || op == NOT;
  endfunction

  // grant ptr on contention, the lone requester otherwise; masked in reset
  always_comb begin
    can_accept = (state_q == IDLE) | resp_ready;
    gnt        = rst_n & can_accept & |req_valid;
    gnt_id     = &req_valid ? ptr_q : req_valid[1];
    req_ready  = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    legal      = is_legal(req_opcode[gnt_id]);
  end

  logical_unit u_lu (
    .opcode_i (req_opcode[gnt_id]),
    .op1_i    (req_op1[gnt_id]),
    .op2_i    (req_op2[gnt_id]),
    .result_o (lu_res)
  );

  // a grant loads a fresh result; a drained result with no grant returns to IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    if (gnt) begin
      state_d = HOLD;
      data_d  = legal ? lu_res : '0;
      id_d    = gnt_id;
      err_d   = ~legal;
      ptr_d   = ~gnt_id;
    end else if (resp_ready) begin
      state_d = IDLE;
    end
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == HOLD);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;
endmodule
